// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit and its queue.
package branch_resolve_unit_pkg;

    typedef logic [63:0] pc_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam pc_t INSTR_BYTES = 64'd4;

    // One in-flight prediction: the fetched PC and the target the buffer predicted.
    typedef struct packed {
        pc_t pc;
        pc_t pred;
    } entry_t;

    // Sequential successor PC; wraps modulo 2^64.
    function automatic pc_t next_seq_pc(input pc_t pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch, execute, redirect and update signals of the branch resolve unit.
interface branch_resolve_unit_if;
    import branch_resolve_unit_pkg::*;

    logic        en;
    logic        fetch_valid;
    pc_t         fetch_pc;
    pc_t         fetch_pred_pc;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    pc_t         ex_target;
    logic        redirect_valid;
    pc_t         redirect_pc;
    logic        upd_en;
    pc_t         upd_pc;
    pc_t         upd_target;
    logic        upd_taken;
    logic        upd_jumped;
    logic        queue_full;
    logic [31:0] mispredict_count;
    logic        underflow_err;

    // Pipeline side: issues fetches and resolutions, consumes redirects and updates.
    modport master (
        output en, fetch_valid, fetch_pc, fetch_pred_pc,
        output ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_target,
        input  redirect_valid, redirect_pc,
        input  upd_en, upd_pc, upd_target, upd_taken, upd_jumped,
        input  queue_full, mispredict_count, underflow_err
    );

    // Resolve unit side.
    modport slave (
        input  en, fetch_valid, fetch_pc, fetch_pred_pc,
        input  ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_target,
        output redirect_valid, redirect_pc,
        output upd_en, upd_pc, upd_target, upd_taken, upd_jumped,
        output queue_full, mispredict_count, underflow_err
    );

endinterface

// File: rtl/branch_resolve_unit_pred_fifo.sv
// Small FIFO of in-flight predictions with a same-cycle head read and a flush.
module pred_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    // The resolver needs the head entry in the same cycle it pops, so the
    // read is asynchronous; the queue is tiny and maps to distributed storage.
    assign rdata   = mem[rd_ptr_reg];
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Entry storage; a flushed push is discarded anyway, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers and occupancy; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
            else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares resolved branch/jump outcomes against queued fetch predictions,
// issuing redirects on mispredict and target-buffer updates on taken paths.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 arst_n,
    branch_resolve_unit_if.slave bus
);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t             state_reg;
    logic [CNT_W-1:0]   flush_cnt_reg;
    logic               redirect_valid_reg;
    pc_t                redirect_pc_reg;
    logic               upd_en_reg;
    pc_t                upd_pc_reg;
    pc_t                upd_target_reg;
    logic               upd_taken_reg;
    logic               upd_jumped_reg;
    logic [31:0]        mispredict_count_reg;
    logic               underflow_err_reg;

    entry_t             head;
    entry_t             push_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop_go;
    logic               push_go;
    logic               taken_path;
    logic               mispredict;
    pc_t                actual_pc;
    pc_t                predicted_pc;

    assign push_entry = '{pc: bus.fetch_pc, pred: bus.fetch_pred_pc};

    // ex_valid is only honoured in RUN; during FLUSH the queue is empty by design.
    assign pop_go       = bus.en & bus.ex_valid & ~fifo_empty & (state_reg == RUN);
    assign push_go      = bus.en & bus.fetch_valid & (state_reg == RUN) & (~fifo_full | pop_go);
    assign taken_path   = (bus.ex_is_branch & bus.ex_taken) | bus.ex_is_jump;
    assign actual_pc    = taken_path ? bus.ex_target : next_seq_pc(head.pc);
    assign predicted_pc = (head.pred != '0) ? head.pred : next_seq_pc(head.pc);
    assign mispredict   = pop_go & (actual_pc != predicted_pc);

    pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (128)
    ) u_pred_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .push   (push_go),
        .pop    (pop_go),
        .flush  (mispredict),
        .wdata  (push_entry),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // RUN/FLUSH control plus all registered outputs; pulses clear every edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg            <= RUN;
            flush_cnt_reg        <= '0;
            redirect_valid_reg   <= 1'b0;
            redirect_pc_reg      <= '0;
            upd_en_reg           <= 1'b0;
            upd_pc_reg           <= '0;
            upd_target_reg       <= '0;
            upd_taken_reg        <= 1'b0;
            upd_jumped_reg       <= 1'b0;
            mispredict_count_reg <= '0;
            underflow_err_reg    <= 1'b0;
        end else begin
            redirect_valid_reg <= 1'b0;
            upd_en_reg         <= 1'b0;
            if (bus.en) begin
                case (state_reg)
                    RUN: begin
                        if (mispredict) begin
                            state_reg     <= FLUSH;
                            flush_cnt_reg <= CNT_W'(FLUSH_CYCLES - 1);
                        end
                        if (bus.ex_valid && fifo_empty) begin
                            underflow_err_reg <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        // The redirect cycle is the first of the FLUSH_CYCLES blocked cycles.
                        if (flush_cnt_reg == '0) state_reg <= RUN;
                        else                     flush_cnt_reg <= flush_cnt_reg - 1'b1;
                    end
                    default: state_reg <= RUN;
                endcase
            end
            if (mispredict) begin
                redirect_valid_reg <= 1'b1;
                redirect_pc_reg    <= actual_pc;
                if (mispredict_count_reg != 32'hFFFF_FFFF) begin
                    mispredict_count_reg <= mispredict_count_reg + 1'b1;
                end
            end
            if (pop_go && taken_path) begin
                upd_en_reg     <= 1'b1;
                upd_pc_reg     <= head.pc;
                upd_target_reg <= bus.ex_target;
                upd_taken_reg  <= bus.ex_is_branch & bus.ex_taken & ~bus.ex_is_jump;
                upd_jumped_reg <= bus.ex_is_jump;
            end
        end
    end

    assign bus.redirect_valid   = redirect_valid_reg;
    assign bus.redirect_pc      = redirect_pc_reg;
    assign bus.upd_en           = upd_en_reg;
    assign bus.upd_pc           = upd_pc_reg;
    assign bus.upd_target       = upd_target_reg;
    assign bus.upd_taken        = upd_taken_reg;
    assign bus.upd_jumped       = upd_jumped_reg;
    assign bus.queue_full       = fifo_full;
    assign bus.mispredict_count = mispredict_count_reg;
    assign bus.underflow_err    = underflow_err_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
    logic clk;
    logic arst_n;
    int   checks;
    int   passed;

    branch_resolve_unit_if bus ();

    branch_resolve_unit #(
        .DEPTH        (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
            $display("check %-22s obs=%h exp=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fetch_valid   = 1'b0;
        bus.fetch_pc      = '0;
        bus.fetch_pred_pc = '0;
        bus.ex_valid      = 1'b0;
        bus.ex_is_branch  = 1'b0;
        bus.ex_is_jump    = 1'b0;
        bus.ex_taken      = 1'b0;
        bus.ex_target     = '0;
    endtask

    task automatic set_fetch(input logic [63:0] pc, input logic [63:0] pred);
        bus.fetch_valid   = 1'b1;
        bus.fetch_pc      = pc;
        bus.fetch_pred_pc = pred;
    endtask

    task automatic set_ex(input logic br, input logic jmp, input logic tkn, input logic [63:0] tgt);
        bus.ex_valid     = 1'b1;
        bus.ex_is_branch = br;
        bus.ex_is_jump   = jmp;
        bus.ex_taken     = tkn;
        bus.ex_target    = tgt;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        arst_n = 1'b0;
        bus.en = 1'b1;
        idle();

        // Reset state
        #3;
        check("rst_redirect_valid", bus.redirect_valid, 0);
        check("rst_upd_en", bus.upd_en, 0);
        check("rst_queue_full", bus.queue_full, 0);
        check("rst_mispredict_count", bus.mispredict_count, 0);
        check("rst_underflow_err", bus.underflow_err, 0);
        #9 arst_n = 1'b1;
        tick();

        // Correct not-taken
        set_fetch(64'h100, 64'h0); tick(); idle();
        set_ex(1, 0, 0, 64'h0);    tick(); idle();
        check("nt_redirect_valid", bus.redirect_valid, 0);
        check("nt_upd_en", bus.upd_en, 0);

        // Correct taken
        set_fetch(64'h100, 64'h200); tick(); idle();
        set_ex(1, 0, 1, 64'h200);    tick(); idle();
        check("tk_upd_en", bus.upd_en, 1);
        check("tk_upd_pc", bus.upd_pc, 64'h100);
        check("tk_upd_target", bus.upd_target, 64'h200);
        check("tk_upd_taken", bus.upd_taken, 1);
        check("tk_upd_jumped", bus.upd_jumped, 0);
        check("tk_redirect_valid", bus.redirect_valid, 0);
        tick();
        check("tk_upd_en_pulse_end", bus.upd_en, 0);

        // Mispredict with simultaneous update
        set_fetch(64'h104, 64'h0); tick();
        set_fetch(64'h108, 64'h0); tick(); idle();
        set_ex(1, 0, 1, 64'h400);  tick(); idle();
        check("mp_redirect_valid", bus.redirect_valid, 1);
        check("mp_redirect_pc", bus.redirect_pc, 64'h400);
        check("mp_count", bus.mispredict_count, 1);
        check("mp_upd_en", bus.upd_en, 1);
        check("mp_upd_pc", bus.upd_pc, 64'h104);
        // Two FLUSH cycles: pushes and ex_valid must both be ignored
        set_fetch(64'h500, 64'h0); set_ex(1, 0, 0, 64'h0); tick();
        check("mp_redirect_pulse_end", bus.redirect_valid, 0);
        tick(); idle();
        check("fl_underflow_ignored", bus.underflow_err, 0);
        check("fl_queue_not_full", bus.queue_full, 0);

        // Fill: queue must hold only these four entries
        set_fetch(64'h1000, 64'h0); tick();
        set_fetch(64'h1004, 64'h0); tick();
        set_fetch(64'h1008, 64'h0); tick();
        check("fill3_not_full", bus.queue_full, 0);
        set_fetch(64'h100C, 64'h0); tick();
        check("fill4_full", bus.queue_full, 1);
        // Simultaneous push and pop on full
        set_fetch(64'h1010, 64'h0); set_ex(0, 1, 0, 64'h1004); tick(); idle();
        check("sim_full", bus.queue_full, 1);
        check("sim_upd_pc", bus.upd_pc, 64'h1000);
        check("sim_upd_jumped", bus.upd_jumped, 1);
        check("sim_upd_taken", bus.upd_taken, 0);
        check("sim_redirect_valid", bus.redirect_valid, 0);
        // Push-only while full is dropped
        set_fetch(64'h2000, 64'h3000); tick(); idle();
        check("drop_full", bus.queue_full, 1);
        set_ex(0, 1, 0, 64'h1008); tick(); idle();
        check("drain0_upd_pc", bus.upd_pc, 64'h1004);
        check("drain0_full", bus.queue_full, 0);
        set_ex(0, 1, 0, 64'h100C); tick(); idle();
        check("drain1_upd_pc", bus.upd_pc, 64'h1008);
        set_ex(0, 1, 0, 64'h1010); tick(); idle();
        check("drain2_upd_pc", bus.upd_pc, 64'h100C);
        set_ex(0, 1, 0, 64'h1014); tick(); idle();
        check("drain3_upd_pc", bus.upd_pc, 64'h1010);
        check("drain3_redirect", bus.redirect_valid, 0);
        check("drain3_count", bus.mispredict_count, 1);

        // Stall: ex_valid on empty queue with en=0 has no effect
        bus.en = 1'b0; set_ex(1, 0, 0, 64'h0); tick(); idle();
        check("stall_underflow", bus.underflow_err, 0);
        check("stall_upd_en", bus.upd_en, 0);
        bus.en = 1'b1;

        // Wrap: pc+4 wraps to 0 and matches pred=0 fallback
        set_fetch(64'hFFFF_FFFF_FFFF_FFFC, 64'h0); tick(); idle();
        set_ex(1, 0, 0, 64'h0); tick(); idle();
        check("wrap_redirect", bus.redirect_valid, 0);
        check("wrap_upd_en", bus.upd_en, 0);
        // Underflow on empty queue
        set_ex(1, 0, 1, 64'h40); tick(); idle();
        check("uf_err", bus.underflow_err, 1);
        check("uf_redirect", bus.redirect_valid, 0);
        check("uf_upd_en", bus.upd_en, 0);

        // Reset mid-FLUSH
        set_fetch(64'h600, 64'h700); tick(); idle();
        set_ex(1, 0, 0, 64'h0); tick(); idle();
        check("rf_redirect_valid", bus.redirect_valid, 1);
        check("rf_redirect_pc", bus.redirect_pc, 64'h604);
        check("rf_count", bus.mispredict_count, 2);
        #2 arst_n = 1'b0;
        #1;
        check("rf_rst_redirect", bus.redirect_valid, 0);
        check("rf_rst_redirect_pc", bus.redirect_pc, 0);
        check("rf_rst_count", bus.mispredict_count, 0);
        check("rf_rst_underflow", bus.underflow_err, 0);
        check("rf_rst_upd_pc", bus.upd_pc, 0);
        #2 arst_n = 1'b1;
        set_fetch(64'h800, 64'h0); tick(); idle();
        check("rf_post_redirect", bus.redirect_valid, 0);
        set_ex(0, 1, 0, 64'h804); tick(); idle();
        check("rf_post_upd_en", bus.upd_en, 1);
        check("rf_post_upd_pc", bus.upd_pc, 64'h800);
        check("rf_post_redirect2", bus.redirect_valid, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameters SHALL be:
- DEPTH, 4: in-flight prediction queue entries, power of two.
- FLUSH_CYCLES, 2: cycles fetch pushes are blocked after a redirect, minimum 1.
REQ-002 Ports SHALL be:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- en  in  1  global stall; when 0, all state holds and registered outputs hold
- fetch_valid  in  1  fetch issued fetch_pc this cycle
- fetch_pc  in  64  PC of fetched instruction
- fetch_pred_pc  in  64  predicted target from the target buffer; 0 = no prediction
- ex_valid  in  1  execute stage resolves its oldest in-flight instruction
- ex_is_branch  in  1  resolved instruction is a conditional branch
- ex_is_jump  in  1  resolved instruction is an unconditional jump
- ex_taken  in  1  branch outcome
- ex_target  in  64  computed branch or jump target
- redirect_valid  out  1  one-cycle pulse: fetch must restart at redirect_pc
- redirect_pc  out  64  correct next PC
- upd_en  out  1  one-cycle target buffer write strobe
- upd_pc  out  64  PC of resolved instruction
- upd_target  out  64  target to store
- upd_taken  out  1  write caused by a taken branch
- upd_jumped  out  1  write caused by a jump
- queue_full  out  1  combinational; queue holds DEPTH entries
- mispredict_count  out  32  saturating count of redirects
- underflow_err  out  1  sticky; ex_valid seen with empty queue

Function
REQ-003 Each queue entry SHALL hold {fetch_pc, fetch_pred_pc} in FIFO order.
REQ-004 Push SHALL occur when en & fetch_valid & state==RUN & (!queue_full | pop this cycle).
REQ-005 Pop SHALL occur when en & ex_valid & queue non-empty; a simultaneous push and pop on a full queue SHALL both succeed, with occupancy unchanged.
REQ-006 A push while full without a pop SHALL be dropped, and the queue SHALL be unchanged.
REQ-007 On pop, the unit SHALL compute two values, with 64-bit arithmetic wrapping modulo 2^64:
- actual = ex_target if (ex_is_branch & ex_taken) | ex_is_jump, else pc+4.
- predicted = pred if pred!=0, else pc+4.
REQ-008 If actual != predicted, the next cycle SHALL show redirect_valid=1 and redirect_pc=actual; the queue SHALL be emptied; the state SHALL become FLUSH; mispredict_count SHALL increment, saturating at 0xFFFFFFFF.
REQ-009 The state machine SHALL have two states:
- RUN -> FLUSH on mispredict.
- FLUSH SHALL last exactly FLUSH_CYCLES enabled cycles, counted from the redirect cycle, and then return to RUN.
- In FLUSH, pushes SHALL be ignored.
- In FLUSH, ex_valid SHALL be ignored and SHALL NOT set underflow_err.
REQ-010 On pop with (ex_is_branch & ex_taken) | ex_is_jump, the next cycle SHALL show upd_en=1, upd_pc=entry pc, upd_target=ex_target, upd_taken=ex_is_branch & ex_taken, and upd_jumped=ex_is_jump; ex_is_jump SHALL take precedence if both are set.
REQ-011 Update and redirect SHALL both fire when a single pop requires both.
REQ-012 Pulse outputs SHALL be 0 on every cycle without a qualifying pop, including all cycles with en=0.
REQ-013 ex_valid with an empty queue in RUN SHALL set underflow_err, with no pop, update or redirect.

Reset
REQ-014 While arst_n=0, regardless of clk:
- queue SHALL be empty and state SHALL be RUN.
- All outputs SHALL be 0, except queue_full, which follows occupancy (0).
REQ-015 Reset asserted mid-FLUSH or mid-update SHALL abort the operation, with no pulse after release.
REQ-016 Reset SHALL be the only clear for mispredict_count and underflow_err.

Structure
REQ-017 A shared package SHALL hold the 64-bit PC type, the state enum {RUN, FLUSH}, and the constant INSTR_BYTES=4.
REQ-018 The queue SHALL be a sub-module pred_fifo, parameterised by DEPTH and WIDTH=128, with push, pop, flush, full and empty signals.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Correct not-taken: push pc=0x100, pred=0; pop ex_is_branch=1, ex_taken=0 -> no redirect, no upd_en.
- Correct taken: push 0x100/0x200; pop taken, target 0x200 -> upd_en=1, upd_pc=0x100, upd_target=0x200, upd_taken=1; redirect_valid=0.
- Mispredict: push 0x104/0, 0x108/0; pop 0x104 taken, target 0x400 -> redirect_pc=0x400, queue empty, mispredict_count=1, pushes ignored for 2 cycles.
- Full and simultaneous: fill 4 entries; next cycle push and pop together -> occupancy stays 4; push-only while full is dropped.
- Wrap and underflow: pc=0xFFFFFFFFFFFFFFFC, pred 0, not taken -> predicted=actual=0, no redirect; ex_valid on empty queue -> underflow_err=1.
- Reset mid-FLUSH: assert arst_n=0 during FLUSH -> state RUN, outputs 0, a push is accepted on the first enabled cycle after release.
